// File: rtl/seg_scan_driver_if.sv
// Pattern-bus / display-pin bundle for seg_scan_driver.
// master = upstream pattern source, slave = the scan driver.
interface seg_scan_driver_if;
  logic       enable;
  logic       load;
  logic [6:0] display0;
  logic [6:0] display1;
  logic [6:0] display2;
  logic [6:0] display3;
  logic [6:0] display4;
  logic [6:0] display5;
  logic [6:0] seg_n;
  logic [5:0] an_n;
  logic       frame_done;
  logic       pending;

  modport master (
    output enable, load, display0, display1, display2, display3, display4, display5,
    input  seg_n, an_n, frame_done, pending
  );

  modport slave (
    input  enable, load, display0, display1, display2, display3, display4, display5,
    output seg_n, an_n, frame_done, pending
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Double-buffered six-digit seven-segment scan driver (active-low segments/anodes).
// Optional macro SEG_SCAN_GHOST_BLANK_EN blanks the first BLANK cycles of each digit slot.
module seg_scan_driver #(
  parameter int unsigned DIV   = 16,
  parameter int unsigned BLANK = 2
) (
  input logic               clk,
  input logic               rst,
  seg_scan_driver_if.slave  bus
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2 || BLANK < 1 || BLANK >= DIV) begin : g_bad_cfg
    $error("seg_scan_driver: require DIV >= 2 and 1 <= BLANK < DIV");
  end

  logic [6:0]    din       [6];
  logic [6:0]    act       [6];
  logic [6:0]    act_next  [6];
  logic [6:0]    pend      [6];
  logic [6:0]    pend_next [6];
  logic          pend_v, pend_v_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    dig, dig_next;
  logic          boundary;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic          fd_q, fd_d;

  always_comb begin
    din[0] = bus.display0;
    din[1] = bus.display1;
    din[2] = bus.display2;
    din[3] = bus.display3;
    din[4] = bus.display4;
    din[5] = bus.display5;
  end

  always_comb begin
    boundary    = (cnt == CW'(DIV - 1)) && (dig == 3'd5);
    cnt_next    = '0;
    dig_next    = '0;
    act_next    = act;
    pend_next   = pend;
    pend_v_next = pend_v;
    if (!bus.enable) begin
      if (bus.load) act_next = din;
    end else begin
      if (cnt == CW'(DIV - 1)) begin
        cnt_next = '0;
        dig_next = (dig == 3'd5) ? 3'd0 : dig + 3'd1;
      end else begin
        cnt_next = cnt + CW'(1);
        dig_next = dig;
      end
      // A load landing on the boundary goes straight to act and supersedes pend.
      if (boundary) begin
        if (bus.load) begin
          act_next    = din;
          pend_v_next = 1'b0;
        end else if (pend_v) begin
          act_next    = pend;
          pend_v_next = 1'b0;
        end
      end else if (bus.load) begin
        pend_next   = din;
        pend_v_next = 1'b1;
      end
    end
  end

  // Outputs are registered from the next scan position so that frame_done
  // lines up with the first output cycle of digit 0 showing the new act.
  always_comb begin
    seg_d = '1;
    an_d  = '1;
    fd_d  = 1'b0;
    if (bus.enable) begin
      fd_d  = boundary;
      seg_d = ~act_next[dig_next];
      an_d  = ~(6'b000001 << dig_next);
`ifdef SEG_SCAN_GHOST_BLANK_EN
      if (cnt_next < CW'(BLANK)) begin
        seg_d = '1;
        an_d  = '1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act    <= '{default: '0};
      pend   <= '{default: '0};
      pend_v <= 1'b0;
      cnt    <= '0;
      dig    <= '0;
      seg_q  <= '1;
      an_q   <= '1;
      fd_q   <= 1'b0;
    end else begin
      act    <= act_next;
      pend   <= pend_next;
      pend_v <= pend_v_next;
      cnt    <= cnt_next;
      dig    <= dig_next;
      seg_q  <= seg_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.seg_n      = seg_q;
  assign bus.an_n       = an_q;
  assign bus.frame_done = fd_q;
  assign bus.pending    = pend_v;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized + directed bench for seg_scan_driver (DIV=4, BLANK=1) against a
// frame-position reference model.
module tb_seg_scan_driver;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BLANK = 1;
  localparam int unsigned FRAME = 6 * DIV;
`ifdef SEG_SCAN_GHOST_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  seg_scan_driver_if bus ();

  seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: frame position 0..FRAME-1 in place of separate counters.
  logic [6:0] m_act  [6];
  logic [6:0] m_pend [6];
  bit         m_pv;
  int         m_pos;
  logic [6:0] e_seg;
  logic [5:0] e_an;
  logic       e_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_act[i]  = '0;
      m_pend[i] = '0;
    end
    m_pv  = 0;
    m_pos = 0;
    e_seg = 7'h7F;
    e_an  = 6'h3F;
    e_fd  = 1'b0;
  endtask

  task automatic model_step();
    logic [6:0] din [6];
    bit frame_end;
    int d;
    din[0] = bus.display0; din[1] = bus.display1; din[2] = bus.display2;
    din[3] = bus.display3; din[4] = bus.display4; din[5] = bus.display5;
    if (!bus.enable) begin
      m_pos = 0;
      if (bus.load) m_act = din;
      e_seg = 7'h7F;
      e_an  = 6'h3F;
      e_fd  = 1'b0;
    end else begin
      frame_end = (m_pos == FRAME - 1);
      if (frame_end) begin
        if (bus.load) begin
          m_act = din;
          m_pv  = 0;
        end else if (m_pv) begin
          m_act = m_pend;
          m_pv  = 0;
        end
      end else if (bus.load) begin
        m_pend = din;
        m_pv   = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
      d     = m_pos / DIV;
      e_fd  = frame_end;
      e_seg = ~m_act[d];
      e_an  = ~(6'(1) << d);
      if (BLANK_EN && (m_pos % DIV) < BLANK) begin
        e_seg = 7'h7F;
        e_an  = 6'h3F;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("seg_n", bus.seg_n, e_seg);
    check("an_n", bus.an_n, e_an);
    check("frame_done", bus.frame_done, e_fd);
    check("pending", bus.pending, m_pv);
    check("one_anode", ($countones(~bus.an_n) <= 1), 1);
  endtask

  task automatic set_disp(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                          input logic [6:0] d3, input logic [6:0] d4, input logic [6:0] d5);
    bus.display0 = d0; bus.display1 = d1; bus.display2 = d2;
    bus.display3 = d3; bus.display4 = d4; bus.display5 = d5;
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while (m_pos != target && n < 4 * FRAME) begin
      tick();
      n++;
    end
    check("wait_pos", m_pos, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, bus.seg_n, 7'h7F);
    check({tag, "_an"}, bus.an_n, 6'h3F);
    check({tag, "_fd"}, bus.frame_done, 1'b0);
    check({tag, "_pend"}, bus.pending, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    set_disp('0, '0, '0, '0, '0, '0);
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Free scan with zero patterns
    bus.enable = 1'b1;
    repeat (2 * FRAME + 2) tick();

    // Load while disabled writes act directly
    bus.enable = 1'b0;
    bus.load   = 1'b1;
    set_disp(7'h3F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h06);
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick();
    check("dig0_pattern", bus.seg_n, 7'h40);
    check("dig0_anode", bus.an_n, 6'h3E);
    repeat (5 * DIV) tick();
    check("dig5_pattern", bus.seg_n, 7'h79);
    check("dig5_anode", bus.an_n, 6'h1F);

    // Tear-free update requested during digit 2
    wait_pos(2 * DIV + 1);
    bus.load = 1'b1;
    set_disp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    tick();
    bus.load = 1'b0;
    check("tear_pending", bus.pending, 1'b1);
    n = 0;
    while (bus.frame_done !== 1'b1 && n < FRAME + 2) begin
      tick();
      n++;
    end
    check("tear_frame_done", bus.frame_done, 1'b1);
    check("tear_pending_clr", bus.pending, 1'b0);
    tick();
    check("tear_new_pattern", bus.seg_n, 7'h00);
    repeat (FRAME) tick();

    // Load exactly on the frame boundary
    wait_pos(FRAME - 1);
    bus.load = 1'b1;
    set_disp(7'h5B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    tick();
    bus.load = 1'b0;
    check("bypass_fd", bus.frame_done, 1'b1);
    check("bypass_seg", bus.seg_n, BLANK_EN ? 7'h7F : 7'h24);
    check("bypass_pending", bus.pending, 1'b0);
    repeat (DIV) tick();

    // Drop enable at digit 3, then re-enable
    wait_pos(3 * DIV + 1);
    bus.enable = 1'b0;
    tick();
    check("drop_an", bus.an_n, 6'h3F);
    check("drop_fd", bus.frame_done, 1'b0);
    repeat (3) tick();
    bus.enable = 1'b1;
    tick();
    check("restart_an", bus.an_n, 6'h3E);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.enable = ($urandom_range(0, 19) != 0);
      bus.load   = ($urandom_range(0, 7) == 0);
      set_disp(7'($urandom), 7'($urandom), 7'($urandom),
               7'($urandom), 7'($urandom), 7'($urandom));
      tick();
    end
    bus.enable = 1'b1;
    bus.load   = 1'b0;
    repeat (FRAME) tick();

    // Asynchronous reset while an update is pending
    wait_pos(5);
    bus.load = 1'b1;
    set_disp(7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66);
    tick();
    bus.load = 1'b0;
    check("pre_rst_pending", bus.pending, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
